rename_dispatch: RTL and testbench

- Front-end rename stage; the producer side of the ROB entry interface.
- Renames arch source/dest registers through a speculative RAT and a physical-register free list.
- Pushes one ROB entry per accepted instruction; back-pressured by the ROB full flag.
- Physical registers released at retire return through a free port.

---
 rtl/rename_dispatch_pkg.sv | 41 ++++
 rtl/rename_dispatch_free_list.sv | 65 ++++++
 rtl/rename_dispatch.sv | 124 ++++++++++++
 tb/tb_rename_dispatch.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_dispatch_pkg.sv
// -----------------------------------------------------------------------------
// rename_dispatch_pkg
// Shared configuration for the rename stage and the ROB that consumes its
// entries: register-file sizes, derived widths, ROB entry layout and the
// free-list pointer wrap helper.
//
// ROB entry layout (MSB..LSB): {dst_valid, arch_dst, new_phys, old_phys}
// The ROB decodes entries with the *_LSB / DST_VALID_BIT offsets below.
// -----------------------------------------------------------------------------
package rename_dispatch_pkg;

   localparam int NUM_ARCH_REGS  = 32;
   localparam int NUM_PHYS_REGS  = 64;
   localparam int LOG_ARCH       = $clog2(NUM_ARCH_REGS);
   localparam int LOG_PHYS       = $clog2(NUM_PHYS_REGS);
   localparam int FREE_DEPTH     = NUM_PHYS_REGS - NUM_ARCH_REGS;
   localparam int LOG_FREE       = (FREE_DEPTH > 1) ? $clog2(FREE_DEPTH) : 1;
   localparam int CNT_BITS       = $clog2(FREE_DEPTH + 1);
   localparam int ROB_ENTRY_BITS = 1 + LOG_ARCH + 2 * LOG_PHYS;

   localparam int OLD_PHYS_LSB   = 0;
   localparam int NEW_PHYS_LSB   = LOG_PHYS;
   localparam int ARCH_DST_LSB   = 2 * LOG_PHYS;
   localparam int DST_VALID_BIT  = 2 * LOG_PHYS + LOG_ARCH;

   typedef struct packed {
      logic                dst_valid;
      logic [LOG_ARCH-1:0] arch_dst;
      logic [LOG_PHYS-1:0] new_phys;
      logic [LOG_PHYS-1:0] old_phys;
   } rob_entry_t;

   // Wrap by explicit compare so FREE_DEPTH need not be a power of two.
   function automatic logic [LOG_FREE-1:0] free_ptr_inc(input logic [LOG_FREE-1:0] p);
      if (p == LOG_FREE'(FREE_DEPTH - 1))
         return '0;
      else
         return p + LOG_FREE'(1);
   endfunction

endpackage

// File: rtl/rename_dispatch_free_list.sv
// -----------------------------------------------------------------------------
// free_list_fifo
// Circular FIFO of free physical register numbers. Reset preloads it with
// NUM_ARCH_REGS..NUM_PHYS_REGS-1 in ascending order (full).
//
// Ports:
//   CLK, RESET        clock / async active-low reset
//   push, push_phys   return a register released at retire
//   pop               consume the head entry (caller guarantees count>0)
//   pop_phys          current head entry (combinational read)
//   count             number of free registers held
// A push while full is dropped and reported in simulation.
// -----------------------------------------------------------------------------
module free_list_fifo
   import rename_dispatch_pkg::*;
(
   input  logic                CLK,
   input  logic                RESET,
   input  logic                push,
   input  logic [LOG_PHYS-1:0] push_phys,
   input  logic                pop,
   output logic [LOG_PHYS-1:0] pop_phys,
   output logic [CNT_BITS-1:0] count
);

   logic [LOG_PHYS-1:0] mem [FREE_DEPTH];
   logic [LOG_FREE-1:0] head;
   logic [LOG_FREE-1:0] tail;
   logic                push_ok;
   logic                pop_ok;

   assign push_ok  = push && (count != CNT_BITS'(FREE_DEPTH));
   assign pop_ok   = pop && (count != '0);
   assign pop_phys = mem[head];

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < FREE_DEPTH; i++)
            mem[i] <= LOG_PHYS'(NUM_ARCH_REGS + i);
         head  <= '0;
         tail  <= '0;
         count <= CNT_BITS'(FREE_DEPTH);
      end else begin
         if (push_ok) begin
            mem[tail] <= push_phys;
            tail      <= free_ptr_inc(tail);
         end
         if (pop_ok)
            head <= free_ptr_inc(head);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CNT_BITS'(1);
            2'b01:   count <= count - CNT_BITS'(1);
            default: count <= count;
         endcase
      end
   end

`ifndef SYNTHESIS
   always @(posedge CLK) begin
      if (RESET && push && (count == CNT_BITS'(FREE_DEPTH)))
         $display("free_list_fifo: error: push of p%0d while full ignored", push_phys);
   end
`endif

endmodule

// File: rtl/rename_dispatch.sv
// -----------------------------------------------------------------------------
// rename_dispatch
// Front-end rename stage. Maps architectural sources/destination through a
// speculative RAT, allocates new destinations from the free list and pushes
// one ROB entry per accepted instruction (1-cycle latency).
//
// Ports:
//   CLK, RESET                       clock / async active-low reset
//   Inst_valid_IN, Dst_valid_IN      decoded instruction / writes a register
//   Arch_src1_IN, Arch_src2_IN       architectural sources
//   Arch_dst_IN                      architectural destination
//   Stall_OUT                        combinational: instruction not accepted
//   Rob_full_IN                      ROB back-pressure
//   Rob_valid_OUT, Rob_entry_OUT     registered ROB entry push
//   Phys_src1_OUT, Phys_src2_OUT     registered renamed sources
//   Free_valid_IN, Free_phys_IN      register released at retire
//   Stall_cnt_OUT                    saturating stall-cycle count (RENAME_STATS_EN)
//
// Build option: RENAME_STATS_EN adds Stall_cnt_OUT and a per-accept trace.
// -----------------------------------------------------------------------------
module rename_dispatch
   import rename_dispatch_pkg::*;
(
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic                      Inst_valid_IN,
   input  logic                      Dst_valid_IN,
   input  logic [LOG_ARCH-1:0]       Arch_src1_IN,
   input  logic [LOG_ARCH-1:0]       Arch_src2_IN,
   input  logic [LOG_ARCH-1:0]       Arch_dst_IN,
   output logic                      Stall_OUT,
   input  logic                      Rob_full_IN,
   output logic                      Rob_valid_OUT,
   output logic [ROB_ENTRY_BITS-1:0] Rob_entry_OUT,
   output logic [LOG_PHYS-1:0]       Phys_src1_OUT,
   output logic [LOG_PHYS-1:0]       Phys_src2_OUT,
`ifdef RENAME_STATS_EN
   output logic [31:0]               Stall_cnt_OUT,
`endif
   input  logic                      Free_valid_IN,
   input  logic [LOG_PHYS-1:0]       Free_phys_IN
);

   logic [LOG_PHYS-1:0] rat [NUM_ARCH_REGS];
   logic                dst_eff;
   logic                accept;
   logic                alloc;
   logic [CNT_BITS-1:0] free_count;
   logic [LOG_PHYS-1:0] free_head;
   rob_entry_t          entry_d;

   // r0 is hardwired and never gets a new mapping.
   assign dst_eff   = Dst_valid_IN && (Arch_dst_IN != '0);
   // A register freed this cycle only lands in count next cycle, so an
   // empty list stalls even with a concurrent free.
   assign accept    = Inst_valid_IN && !Rob_full_IN && (!dst_eff || (free_count != '0));
   assign Stall_OUT = Inst_valid_IN && !accept;
   assign alloc     = accept && dst_eff;

   free_list_fifo u_free (
      .CLK       (CLK),
      .RESET     (RESET),
      .push      (Free_valid_IN),
      .push_phys (Free_phys_IN),
      .pop       (alloc),
      .pop_phys  (free_head),
      .count     (free_count)
   );

   always_comb begin
      entry_d = '0;
      if (dst_eff) begin
         entry_d.dst_valid = 1'b1;
         entry_d.arch_dst  = Arch_dst_IN;
         entry_d.new_phys  = free_head;
         entry_d.old_phys  = rat[Arch_dst_IN];
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int i = 0; i < NUM_ARCH_REGS; i++)
            rat[i] <= LOG_PHYS'(i);
      end else if (alloc) begin
         rat[Arch_dst_IN] <= free_head;
      end
   end

   // Sources read the RAT as it was before this instruction's own update.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         Rob_valid_OUT <= 1'b0;
         Rob_entry_OUT <= '0;
         Phys_src1_OUT <= '0;
         Phys_src2_OUT <= '0;
      end else begin
         Rob_valid_OUT <= accept;
         if (accept) begin
            Rob_entry_OUT <= entry_d;
            Phys_src1_OUT <= rat[Arch_src1_IN];
            Phys_src2_OUT <= rat[Arch_src2_IN];
         end
      end
   end

`ifdef RENAME_STATS_EN
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET)
         Stall_cnt_OUT <= '0;
      else if (Stall_OUT && (Stall_cnt_OUT != '1))
         Stall_cnt_OUT <= Stall_cnt_OUT + 32'd1;
   end

`ifndef SYNTHESIS
   always @(posedge CLK) begin
      if (RESET && accept)
         $display("rename: r%0d->p%0d r%0d->p%0d dst %0d r%0d->p%0d (old p%0d)",
                  Arch_src1_IN, rat[Arch_src1_IN], Arch_src2_IN, rat[Arch_src2_IN],
                  entry_d.dst_valid, Arch_dst_IN, entry_d.new_phys, entry_d.old_phys);
   end
`endif
`endif

endmodule

// File: tb/tb_rename_dispatch.sv
module tb_rename_dispatch;
   import rename_dispatch_pkg::*;

   logic                      CLK = 1'b0;
   logic                      RESET;
   logic                      Inst_valid_IN, Dst_valid_IN, Rob_full_IN, Free_valid_IN;
   logic [LOG_ARCH-1:0]       Arch_src1_IN, Arch_src2_IN, Arch_dst_IN;
   logic [LOG_PHYS-1:0]       Free_phys_IN;
   logic                      Stall_OUT, Rob_valid_OUT;
   logic [ROB_ENTRY_BITS-1:0] Rob_entry_OUT;
   logic [LOG_PHYS-1:0]       Phys_src1_OUT, Phys_src2_OUT;
`ifdef RENAME_STATS_EN
   logic [31:0]               Stall_cnt_OUT;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   always #5 CLK = ~CLK;

   rename_dispatch dut (
      .CLK           (CLK),
      .RESET         (RESET),
      .Inst_valid_IN (Inst_valid_IN),
      .Dst_valid_IN  (Dst_valid_IN),
      .Arch_src1_IN  (Arch_src1_IN),
      .Arch_src2_IN  (Arch_src2_IN),
      .Arch_dst_IN   (Arch_dst_IN),
      .Stall_OUT     (Stall_OUT),
      .Rob_full_IN   (Rob_full_IN),
      .Rob_valid_OUT (Rob_valid_OUT),
      .Rob_entry_OUT (Rob_entry_OUT),
      .Phys_src1_OUT (Phys_src1_OUT),
      .Phys_src2_OUT (Phys_src2_OUT),
`ifdef RENAME_STATS_EN
      .Stall_cnt_OUT (Stall_cnt_OUT),
`endif
      .Free_valid_IN (Free_valid_IN),
      .Free_phys_IN  (Free_phys_IN)
   );

   function automatic logic [ROB_ENTRY_BITS-1:0] mk_entry(input int a, input int np, input int op);
      rob_entry_t e;
      e.dst_valid = 1'b1;
      e.arch_dst  = LOG_ARCH'(a);
      e.new_phys  = LOG_PHYS'(np);
      e.old_phys  = LOG_PHYS'(op);
      return e;
   endfunction

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      Inst_valid_IN = 0; Dst_valid_IN = 0; Rob_full_IN = 0; Free_valid_IN = 0;
      Arch_src1_IN = '0; Arch_src2_IN = '0; Arch_dst_IN = '0; Free_phys_IN = '0;
   endtask

   task automatic set_inst(input bit dv, input int s1, input int s2, input int d);
      Inst_valid_IN = 1; Dst_valid_IN = dv;
      Arch_src1_IN = LOG_ARCH'(s1); Arch_src2_IN = LOG_ARCH'(s2); Arch_dst_IN = LOG_ARCH'(d);
   endtask

   task automatic do_reset();
      idle();
      @(negedge CLK);
      RESET = 0;
      #3;
      RESET = 1;
      #1;
   endtask

   task automatic test_reset();
      idle();
      RESET = 0;
      #12;
      n_checks++;
      if (Rob_valid_OUT !== 1'b0 || Rob_entry_OUT !== '0 || Phys_src1_OUT !== '0 || Phys_src2_OUT !== '0)
         $display("FAIL reset_outputs: got v=%b e=%h s1=%0d s2=%0d, want all 0",
                  Rob_valid_OUT, Rob_entry_OUT, Phys_src1_OUT, Phys_src2_OUT);
      else n_pass++;
      n_checks++;
      if (dut.u_free.count !== CNT_BITS'(32)) $display("FAIL reset_count: got %0d want 32", dut.u_free.count);
      else n_pass++;
      @(negedge CLK);
      RESET = 1;
      tick();
   endtask

   task automatic test_first_alloc();
      do_reset();
      set_inst(1, 0, 0, 5);
      n_checks++;
      if (Stall_OUT !== 1'b0) $display("FAIL first_stall: got %b want 0", Stall_OUT); else n_pass++;
      tick();
      n_checks++;
      if (Rob_valid_OUT !== 1'b1 || Rob_entry_OUT !== mk_entry(5, 32, 5))
         $display("FAIL first_entry: got v=%b e=%h want v=1 e=%h", Rob_valid_OUT, Rob_entry_OUT, mk_entry(5, 32, 5));
      else n_pass++;
      set_inst(0, 5, 6, 0);
      tick();
      n_checks++;
      if (Rob_valid_OUT !== 1'b1 || Phys_src1_OUT !== 6'd32 || Phys_src2_OUT !== 6'd6 || Rob_entry_OUT !== '0)
         $display("FAIL read_renamed: got v=%b s1=%0d s2=%0d e=%h want v=1 s1=32 s2=6 e=0",
                  Rob_valid_OUT, Phys_src1_OUT, Phys_src2_OUT, Rob_entry_OUT);
      else n_pass++;
      idle();
      tick();
      n_checks++;
      if (Rob_valid_OUT !== 1'b0 || Phys_src1_OUT !== 6'd32)
         $display("FAIL idle_hold: got v=%b s1=%0d want v=0 s1=32", Rob_valid_OUT, Phys_src1_OUT);
      else n_pass++;
   endtask

   task automatic test_src_eq_dst();
      do_reset();
      set_inst(1, 3, 0, 3);
      tick();
      n_checks++;
      if (Phys_src1_OUT !== 6'd3 || Rob_entry_OUT !== mk_entry(3, 32, 3))
         $display("FAIL src_eq_dst: got s1=%0d e=%h want s1=3 e=%h", Phys_src1_OUT, Rob_entry_OUT, mk_entry(3, 32, 3));
      else n_pass++;
      set_inst(0, 3, 3, 0);
      tick();
      n_checks++;
      if (Phys_src1_OUT !== 6'd32 || Phys_src2_OUT !== 6'd32)
         $display("FAIL after_self_write: got s1=%0d s2=%0d want 32 32", Phys_src1_OUT, Phys_src2_OUT);
      else n_pass++;
      idle();
   endtask

   task automatic test_exhaust();
      int bad;
      do_reset();
      bad = 0;
      for (int i = 0; i < 32; i++) begin
         set_inst(1, 0, 0, (i % 31) + 1);
         if (Stall_OUT !== 1'b0) bad++;
         tick();
         if (Rob_valid_OUT !== 1'b1 || Rob_entry_OUT[NEW_PHYS_LSB +: LOG_PHYS] !== LOG_PHYS'(32 + i)) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL exhaust_allocs: %0d bad cycles, want 0", bad); else n_pass++;
      n_checks++;
      if (dut.u_free.count !== '0) $display("FAIL exhaust_count: got %0d want 0", dut.u_free.count); else n_pass++;
      set_inst(1, 0, 0, 1);
      Free_valid_IN = 1; Free_phys_IN = 6'd7;
      #1;
      n_checks++;
      if (Stall_OUT !== 1'b1) $display("FAIL empty_stall: got %b want 1", Stall_OUT); else n_pass++;
      tick();
      Free_valid_IN = 0;
      #1;
      n_checks++;
      if (Rob_valid_OUT !== 1'b0 || Stall_OUT !== 1'b0)
         $display("FAIL after_free: got v=%b stall=%b want v=0 stall=0", Rob_valid_OUT, Stall_OUT);
      else n_pass++;
      tick();
      n_checks++;
      if (Rob_valid_OUT !== 1'b1 || Rob_entry_OUT !== mk_entry(1, 7, 63))
         $display("FAIL realloc_freed: got v=%b e=%h want v=1 e=%h", Rob_valid_OUT, Rob_entry_OUT, mk_entry(1, 7, 63));
      else n_pass++;
      idle();
   endtask

   task automatic test_rob_full();
      int bad;
      do_reset();
      bad = 0;
      set_inst(1, 2, 0, 2);
      Rob_full_IN = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (Stall_OUT !== 1'b1) bad++;
         tick();
         if (Rob_valid_OUT !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) $display("FAIL rob_full_stall: %0d bad samples, want 0", bad); else n_pass++;
      n_checks++;
      if (dut.u_free.count !== CNT_BITS'(32)) $display("FAIL rob_full_count: got %0d want 32", dut.u_free.count);
      else n_pass++;
      Rob_full_IN = 0;
      #1;
      n_checks++;
      if (Stall_OUT !== 1'b0) $display("FAIL rob_release_stall: got %b want 0", Stall_OUT); else n_pass++;
      tick();
      n_checks++;
      if (Rob_valid_OUT !== 1'b1 || Rob_entry_OUT !== mk_entry(2, 32, 2) || Phys_src1_OUT !== 6'd2)
         $display("FAIL rob_release_entry: got v=%b e=%h s1=%0d want v=1 e=%h s1=2",
                  Rob_valid_OUT, Rob_entry_OUT, Phys_src1_OUT, mk_entry(2, 32, 2));
      else n_pass++;
      idle();
   endtask

   task automatic test_no_dst();
      do_reset();
      set_inst(1, 1, 2, 0);
      tick();
      n_checks++;
      if (Rob_valid_OUT !== 1'b1 || Rob_entry_OUT !== '0 || dut.u_free.count !== CNT_BITS'(32))
         $display("FAIL dst_r0: got v=%b e=%h cnt=%0d want v=1 e=0 cnt=32", Rob_valid_OUT, Rob_entry_OUT, dut.u_free.count);
      else n_pass++;
      set_inst(0, 4, 0, 4);
      tick();
      n_checks++;
      if (Rob_valid_OUT !== 1'b1 || Rob_entry_OUT !== '0 || dut.u_free.count !== CNT_BITS'(32))
         $display("FAIL dst_invalid: got v=%b e=%h cnt=%0d want v=1 e=0 cnt=32", Rob_valid_OUT, Rob_entry_OUT, dut.u_free.count);
      else n_pass++;
      set_inst(1, 0, 0, 4);
      tick();
      n_checks++;
      if (Rob_entry_OUT !== mk_entry(4, 32, 4))
         $display("FAIL after_no_dst: got e=%h want e=%h", Rob_entry_OUT, mk_entry(4, 32, 4));
      else n_pass++;
      idle();
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 1; i <= 10; i++) begin
         set_inst(1, 0, 0, i);
         tick();
      end
      n_checks++;
      if (Rob_valid_OUT !== 1'b1 || Rob_entry_OUT !== mk_entry(10, 41, 10))
         $display("FAIL pre_reset_entry: got v=%b e=%h want v=1 e=%h", Rob_valid_OUT, Rob_entry_OUT, mk_entry(10, 41, 10));
      else n_pass++;
      idle();
      #1;
      RESET = 0;
      #1;
      n_checks++;
      if (Rob_valid_OUT !== 1'b0 || Rob_entry_OUT !== '0 || dut.u_free.count !== CNT_BITS'(32))
         $display("FAIL async_reset: got v=%b e=%h cnt=%0d want v=0 e=0 cnt=32", Rob_valid_OUT, Rob_entry_OUT, dut.u_free.count);
      else n_pass++;
      @(negedge CLK);
      RESET = 1;
      #1;
      set_inst(1, 6, 0, 6);
      tick();
      n_checks++;
      if (Rob_entry_OUT !== mk_entry(6, 32, 6) || Phys_src1_OUT !== 6'd6)
         $display("FAIL post_reset_alloc: got e=%h s1=%0d want e=%h s1=6", Rob_entry_OUT, Phys_src1_OUT, mk_entry(6, 32, 6));
      else n_pass++;
      idle();
   endtask

   initial begin
      RESET = 1;
      idle();
      test_reset();
      test_first_alloc();
      test_src_eq_dst();
      test_exhaust();
      test_rob_full();
      test_no_dst();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
